mips_mc_control_fsm: RTL

- Multicycle MIPS main control unit: a Moore FSM that sequences fetch/decode/execute/memory/writeback.
- Drives every datapath select and enable, including the 2-bit ALU source-B select consumed by the ALU operand-B mux (00=B reg, 01=const 4, 10=sign_imm, 11=sign_imm<<2).
- Sits directly upstream of the operand muxes, the PC/IR/register-file enables and the ALU decoder (via aluop).
- Adds a memory ready handshake so fetch and load/store states stall on slow memory.

---
 rtl/mips_mc_control_fsm.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mips_mc_control_fsm
//
// Main control unit for a multicycle MIPS datapath. A Moore FSM steps through
// fetch, decode, execute, memory and writeback. It drives every datapath
// select and enable. Fetch and load/store states wait on a memory-ready
// handshake.
//
// Optional feature (macro BNE_EN):
//   When defined, opcode 000101 (bne) decodes to state BNE(12).
//   When undefined, that opcode is dropped like any unknown op, encoding 12 is
//   unused, and branch_ne is tied to 0. The branch_ne port exists in both
//   builds.
//
// Parameters:
//   STATE_W   width of the state register and of state_dbg (must be >= 4)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (state -> FETCH)
//   op         opcode field of the instruction register, instr[31:26]
//   mem_ready  memory has completed the current access this cycle
//   pcwrite    unconditional PC load
//   branch     PC load if ALU zero (beq)
//   branch_ne  PC load if ALU not-zero (bne)
//   iord       memory address select: 0=PC, 1=ALUOut
//   memwrite   memory write strobe
//   irwrite    instruction register load
//   regdst     write-reg select: 0=rt, 1=rd
//   memtoreg   write-data select: 0=ALUOut, 1=MDR
//   regwrite   register file write enable
//   alusrca    ALU A select: 0=PC, 1=A reg
//   alusrcb    ALU B select: 00=B reg, 01=4, 10=sign_imm, 11=sign_imm<<2
//   aluop      00=add, 01=sub, 10=funct-decoded
//   pcsrc      00=ALU result, 01=ALUOut, 10=jump target
//   state_dbg  current state encoding
// -----------------------------------------------------------------------------
module mips_mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               branch,
    output logic               branch_ne,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         pcsrc,
    output logic [STATE_W-1:0] state_dbg
);

    // State encodings
    localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTE = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH  = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDIEX  = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDIWB  = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP    = STATE_W'(11);
`ifdef BNE_EN
    localparam logic [STATE_W-1:0] S_BNE     = STATE_W'(12);
`endif

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. op is only looked at in DECODE and MEMADR, where
    // the IR is stable because irwrite is low outside FETCH.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
`ifdef BNE_EN
                    OP_BNE:       next_state = S_BNE;
`endif
                    default:      next_state = S_FETCH;  // unknown op: drop it
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    next_state = S_MEMRD;
                end else if (op == OP_SW) begin
                    next_state = S_MEMWR;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: next_state = S_ALUWB;
            S_ALUWB:   next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_ADDIEX:  next_state = S_ADDIWB;
            S_ADDIWB:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
`ifdef BNE_EN
            S_BNE:     next_state = S_FETCH;
`endif
            default:   next_state = S_FETCH;  // unused encodings recover
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, apart from the FETCH enables following
    // mem_ready). Write enables are also gated by rst_n so nothing is
    // written while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        pcwrite   = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        pcsrc     = 2'b00;

        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                pcwrite = mem_ready;
                irwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef BNE_EN
            S_BNE: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            default: ;  // unused encodings: everything stays 0
        endcase

        // State is already FETCH while rst_n is low; this only suppresses
        // the mem_ready-driven FETCH enables and any other write strobe.
        if (!rst_n) begin
            pcwrite  = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign state_dbg = state;

endmodule
